// File: rtl/usb_tx_if.sv
// Packet request, buffer read and USB line signals between a packet source and usb_tx.
// The transmitter uses the slave modport; the packet source and buffer side use master.
interface usb_tx_if;
    localparam int unsigned PID_W   = 4;
    localparam int unsigned COUNT_W = 10;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned WORD_W  = 32;

    logic                start;
    logic [PID_W-1:0]    pid;
    logic [COUNT_W-1:0]  byte_count;
    logic [ADDR_W-1:0]   usb_data_buffer_address;
    logic [WORD_W-1:0]   usb_data_buffer_read_value;
    logic                usb_d_p_out;
    logic                usb_d_n_out;
    logic                usb_output_enable;
    logic                busy;
    logic                done;

    modport master (
        output start, pid, byte_count, usb_data_buffer_read_value,
        input  usb_data_buffer_address, usb_d_p_out, usb_d_n_out,
               usb_output_enable, busy, done
    );

    modport slave (
        input  start, pid, byte_count, usb_data_buffer_read_value,
        output usb_data_buffer_address, usb_d_p_out, usb_d_n_out,
               usb_output_enable, busy, done
    );
endinterface

// File: rtl/usb_tx.sv
// Full-speed USB packet transmitter: SYNC, PID, optional data payload with CRC16,
// bit stuffing, NRZI line coding and EOP. One bit time is four clk48 cycles.
module usb_tx (
    input  logic   clk48,
    input  logic   reset_n,
    usb_tx_if.slave bus
);
    localparam int unsigned CRC_W    = 16;
    localparam int unsigned COUNT_W  = 10;
    localparam int unsigned ADDR_W   = 8;
    localparam logic [CRC_W-1:0] CRC_POLY = 16'hA001;
    localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC, EOP_SE0, EOP_J} state_t;

    // state names the field of the next bit to send; idx is the bit position within it
    state_t               state;
    logic [1:0]           phase;
    logic [3:0]           idx;
    logic [2:0]           ones;
    logic [CRC_W-1:0]     crc;
    logic [COUNT_W-1:0]   byte_idx;
    logic [COUNT_W-1:0]   count_r;
    logic [3:0]           pid_r;
    logic                 d_p;
    logic                 d_n;
    logic                 oe;
    logic                 busy_r;
    logic                 done_r;
    logic [ADDR_W-1:0]    addr_r;

    logic                 field_bit_c;
    logic                 field_last_c;
    logic [CRC_W-1:0]     crc_next_c;
    logic [7:0]           pid_byte_c;
    logic [COUNT_W-1:0]   byte_next_c;
    logic                 stuff_c;
    logic                 boundary_c;
    logic                 data_pkt_c;

    assign pid_byte_c  = {~pid_r, pid_r};
    assign byte_next_c = byte_idx + 10'd1;
    assign stuff_c     = (ones == 3'd6);
    assign boundary_c  = (phase == 2'd3);
    assign data_pkt_c  = (pid_r[1:0] == 2'b11);
    assign crc_next_c  = {1'b0, crc[CRC_W-1:1]} ^ ((crc[0] ^ field_bit_c) ? CRC_POLY : 16'h0000);

    // Value of the next unstuffed bit and whether it closes its field
    always_comb begin
        field_bit_c  = 1'b0;
        field_last_c = (idx == 4'd7);
        case (state)
            SYNC:    field_bit_c = (idx == 4'd7);
            PID:     field_bit_c = pid_byte_c[idx[2:0]];
            DATA:    field_bit_c = bus.usb_data_buffer_read_value[{byte_idx[1:0], idx[2:0]}];
            CRC: begin
                field_bit_c  = ~crc[idx];
                field_last_c = (idx == 4'd15);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk48 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            phase    <= 2'd0;
            idx      <= 4'd0;
            ones     <= 3'd0;
            crc      <= CRC_INIT;
            byte_idx <= 10'd0;
            count_r  <= 10'd0;
            pid_r    <= 4'd0;
            d_p      <= 1'b1;
            d_n      <= 1'b0;
            oe       <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            addr_r   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    d_p    <= 1'b1;
                    d_n    <= 1'b0;
                    oe     <= 1'b0;
                    busy_r <= 1'b0;
                    if (bus.start) begin
                        // first SYNC bit (a 0) goes out right away: J toggles to K
                        pid_r    <= bus.pid;
                        count_r  <= bus.byte_count;
                        busy_r   <= 1'b1;
                        oe       <= 1'b1;
                        d_p      <= 1'b0;
                        d_n      <= 1'b1;
                        phase    <= 2'd0;
                        crc      <= CRC_INIT;
                        ones     <= 3'd0;
                        byte_idx <= 10'd0;
                        addr_r   <= 8'd0;
                        state    <= SYNC;
                        idx      <= 4'd1;
                    end
                end
                default: begin
                    phase  <= phase + 2'd1;
                    done_r <= (state == EOP_J) && (idx == 4'd1) && (phase == 2'd2);
                    if (boundary_c) begin
                        case (state)
                            EOP_SE0: begin
                                ones <= 3'd0;
                                if (stuff_c) begin
                                    d_p <= ~d_p;
                                    d_n <= ~d_n;
                                end else begin
                                    d_p <= 1'b0;
                                    d_n <= 1'b0;
                                    if (idx == 4'd1) begin
                                        state <= EOP_J;
                                        idx   <= 4'd0;
                                    end else begin
                                        idx <= 4'd1;
                                    end
                                end
                            end
                            EOP_J: begin
                                d_p <= 1'b1;
                                d_n <= 1'b0;
                                if (idx == 4'd0) begin
                                    idx <= 4'd1;
                                end else begin
                                    state  <= IDLE;
                                    oe     <= 1'b0;
                                    busy_r <= 1'b0;
                                    idx    <= 4'd0;
                                end
                            end
                            default: begin
                                if (stuff_c) begin
                                    d_p  <= ~d_p;
                                    d_n  <= ~d_n;
                                    ones <= 3'd0;
                                end else begin
                                    if (field_bit_c) begin
                                        ones <= ones + 3'd1;
                                    end else begin
                                        d_p  <= ~d_p;
                                        d_n  <= ~d_n;
                                        ones <= 3'd0;
                                    end
                                    if (state == DATA) crc <= crc_next_c;
                                    if (field_last_c) begin
                                        idx <= 4'd0;
                                        case (state)
                                            SYNC: state <= PID;
                                            PID: begin
                                                if (!data_pkt_c)          state <= EOP_SE0;
                                                else if (count_r == 10'd0) state <= CRC;
                                                else                       state <= DATA;
                                            end
                                            DATA: begin
                                                // next word address is ready well before its first bit
                                                byte_idx <= byte_next_c;
                                                addr_r   <= byte_next_c[9:2];
                                                if (byte_next_c == count_r) state <= CRC;
                                            end
                                            default: state <= EOP_SE0;
                                        endcase
                                    end else begin
                                        idx <= idx + 4'd1;
                                    end
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.usb_d_p_out             = d_p;
    assign bus.usb_d_n_out             = d_n;
    assign bus.usb_output_enable       = oe;
    assign bus.busy                    = busy_r;
    assign bus.done                    = done_r;
    assign bus.usb_data_buffer_address = addr_r;
endmodule

// File: doc/usb_tx.md
USB_TX -- requirements
Module: usb_tx

Interface
REQ-001 SHALL have port clk48  input  1  48 MHz clock; all logic on its rising edge.
REQ-002 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port start  input  1  one-cycle request to transmit a packet.
REQ-004 SHALL have port pid  input  4  packet ID nibble, sampled when start is accepted.
REQ-005 SHALL have port byte_count  input  10  data payload length in bytes (0..1023), sampled when start is accepted.
REQ-006 SHALL have port usb_data_buffer_address  output  8  word address into the USB data buffer.
REQ-007 SHALL have port usb_data_buffer_read_value  input  32  buffer word; valid one clk48 after its address.
REQ-008 SHALL have port usb_d_p_out  output  1  driven D+ level.
REQ-009 SHALL have port usb_d_n_out  output  1  driven D- level.
REQ-010 SHALL have port usb_output_enable  output  1  high while the block drives the bus.
REQ-011 SHALL have port busy  output  1  high from the accepted start until done.
REQ-012 SHALL have port done  output  1  one-cycle pulse when the packet is complete.

Function
REQ-013 SHALL accept start only when busy=0; start while busy SHALL be ignored, with no effect on the packet in flight.
REQ-014 SHALL signal at full speed: one bit time = 4 clk48 cycles; first bit driven starting the cycle after start is accepted.
REQ-015 SHALL use these states: IDLE, SYNC, PID, DATA, CRC, EOP_SE0, EOP_J; transitions occur only on bit boundaries.
REQ-016 SHALL send SYNC as bits 0,0,0,0,0,0,0,1 (wire KJKJKJKK from J).
REQ-017 SHALL send the PID byte {~pid, pid}, LSB first.
REQ-018 SHALL treat pid[1:0]=2'b11 as a data packet: PID, then byte_count bytes, then CRC16. Any other pid SHALL be PID-only (handshake) and go directly to EOP_SE0.
REQ-019 SHALL take data byte n from word n[9:2], bits 8*n[1:0]+7 .. 8*n[1:0], LSB first.
REQ-020 SHALL present each word address at least 2 cycles before the word's first bit is needed; usb_data_buffer_address SHALL reset to 0.
REQ-021 SHALL compute CRC16 LSB-first over data bits only, reflected polynomial 0xA001, initial value 0xFFFF.
REQ-022 SHALL transmit the bitwise complement of the CRC register, bit 0 first, 16 bits.
REQ-023 SHALL NRZI-encode: a 0 toggles the J/K line state, a 1 holds it. J: D+=1, D-=0. K: D+=0, D-=1.
REQ-024 SHALL insert a stuffed 0 after every 6 consecutive 1s, counted from the start of SYNC through the last CRC/PID bit, including a stuff after the final bit.
REQ-025 SHALL not feed stuffed bits into the CRC, and SHALL reset the ones count after each stuffed bit.
REQ-026 SHALL drive EOP as SE0 (D+=D-=0) for 2 bit times (8 cycles), then J for 1 bit time (4 cycles).
REQ-027 SHALL pulse done in the last J cycle; usb_output_enable and busy SHALL fall on the following cycle.
REQ-028 SHALL drive J (D+=1, D-=0) with usb_output_enable=0 while IDLE.

Reset
REQ-029 SHALL, on reset_n low at any time including mid-packet, immediately force: state IDLE, usb_d_p_out=1, usb_d_n_out=0, usb_output_enable=0, busy=0, done=0, address=0, CRC=0xFFFF, ones count=0.
REQ-030 SHALL, after reset release, ignore the aborted packet and accept a new start normally.

Verification
REQ-031 ACK: pid=4'b0010 -> wire KJKJKJKK, then PID 0xD2 NRZI, 8 cycles SE0, 4 cycles J; usb_output_enable high 76 cycles; done in cycle 76.
REQ-032 DATA1, zero length: pid=4'b1011, byte_count=0 -> PID 0x4B, CRC bytes 0x00,0x00 (16 alternating line toggles), no stuffing; 140 enabled cycles.
REQ-033 CRC/byte order: buffer words 0x34333231, 0x38373635, 0x00000039; DATA0, byte_count=9 -> bytes "123456789"; CRC bytes 0xC8 then 0xB4; addresses 0,1,2 read in order.
REQ-034 Bit stuffing: DATA0 (0xC3), byte_count=1, byte 0xFF -> stuffed 0 after the 4th data bit (6 ones counted across PID and data); no second stuff; CRC excludes the stuffed bit.
REQ-035 Reset mid-DATA: reset_n low during byte 2 -> bus returns to J with usb_output_enable=0 the same cycle; a new ACK start afterwards transmits exactly as in REQ-031.
REQ-036 Start while busy: a second start during the SYNC of an ACK -> ignored; exactly one packet and one done pulse.
